pool_unit: RTL and testbench

Parametrised multi-channel pooling stage for the post-processing path. It runs CH signed activation lanes in parallel and reduces a window of cfg_win consecutive accepted samples per lane to one result. The result is either the signed average or the signed maximum. It replaces the fixed single-lane averager, adding valid/ready flow control, a runtime window length and a max mode, and it sits between the last PE column output and the activation write-back.

---
 rtl/pool_pkg.sv | 25 ++
 rtl/pool_unit_if.sv | 25 ++
 rtl/seq_div.sv | 61 ++++++
 rtl/pool_unit.sv | 140 ++++++++++++++
 tb/tb_pool_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the multi-lane pooling stage.
package pool_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    DIV = 2'd1,
    OUT = 2'd2
  } state_t;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Accumulator width: one activation plus growth for summing win_max samples.
  function automatic int acc_width(input int act_w, input int win_max);
    return act_w + $clog2(win_max);
  endfunction

  // Effective window length: 0 is treated as 1, anything above win_max saturates.
  function automatic logic [7:0] clip_win(input logic [7:0] w, input int win_max);
    if (w == 8'd0) return 8'd1;
    if (int'(w) > win_max) return 8'(win_max);
    return w;
  endfunction

endpackage

// File: rtl/pool_unit_if.sv
// Stream, configuration and status signals of the pooling stage.
interface pool_unit_if #(
  parameter int ACT_W = 8,
  parameter int CH    = 4
);
  logic                  cfg_mode;
  logic [7:0]            cfg_win;
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*ACT_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*ACT_W-1:0]   out_data;
  logic                  busy;

  modport master (
    output cfg_mode, cfg_win, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  cfg_mode, cfg_win, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// The start cycle already performs the first step, and the final quotient is
// presented combinationally in the cycle where done is high, so back-to-back
// divisions take exactly ACC_W cycles each with no idle gap.
module seq_div #(
  parameter int ACC_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic             done,
  output logic [ACC_W-1:0] quotient
);
  localparam int CNT_W = $clog2(ACC_W) + 1;

  logic             running;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_cur;
  logic [ACC_W-1:0] rem_q, quo_q;
  logic [ACC_W-1:0] a_rem, a_quo, shifted, rem_nxt;
  logic [ACC_W:0]   diff;
  logic             step;
  // Remainder stays below the divisor, so its top bit is always zero.
  logic             unused_rem_msb;

  assign unused_rem_msb = a_rem[ACC_W-1];

  // One restoring step on either fresh operands (start) or the running state.
  always_comb begin
    a_rem    = start ? '0 : rem_q;
    a_quo    = start ? dividend : quo_q;
    cnt_cur  = start ? '0 : cnt_q;
    shifted  = {a_rem[ACC_W-2:0], a_quo[ACC_W-1]};
    diff     = {1'b0, shifted} - {1'b0, divisor};
    rem_nxt  = diff[ACC_W] ? shifted : diff[ACC_W-1:0];
    quotient = {a_quo[ACC_W-2:0], ~diff[ACC_W]};
    step     = start || running;
    done     = step && (cnt_cur == CNT_W'(ACC_W - 1));
  end

  // Step counter and run flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt_q   <= '0;
    end else if (step) begin
      running <= !done;
      cnt_q   <= cnt_cur + CNT_W'(1);
    end
  end

  // Partial remainder and dividend/quotient shift register.
  always_ff @(posedge clk) begin
    if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quotient;
    end
  end
endmodule

// File: rtl/pool_unit.sv
// Multi-lane pooling stage: per-lane signed average or maximum over a
// runtime-configurable window, with valid/ready flow control.
module pool_unit
  import pool_pkg::*;
#(
  parameter int ACT_W   = 8,
  parameter int CH      = 4,
  parameter int WIN_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  pool_unit_if.slave bus
);
  localparam int ACC_W  = acc_width(ACT_W, WIN_MAX);
  localparam int LANE_W = (CH > 1) ? $clog2(CH) : 1;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q;
  logic                    mode_q;
  logic [7:0]              win_q;
  logic [LANE_W-1:0]       lane_q;
  logic                    div_start_q;
  logic [CH*ACT_W-1:0]     out_q;
  logic signed [ACC_W-1:0] acc_q   [CH];
  logic signed [ACC_W-1:0] acc_nxt [CH];
  logic signed [ACC_W-1:0] sext    [CH];
  logic [CH*ACT_W-1:0]     max_pack;

  logic                    fire, first, last, mode_eff;
  logic [7:0]              win_eff;

  logic signed [ACC_W-1:0] div_sel;
  logic [ACC_W-1:0]        div_mag, div_den, div_quo;
  logic                    div_done;
  logic [ACT_W-1:0]        quo_lo, div_res;
  // The quotient magnitude never exceeds 2^(ACT_W-1), so only the low bits matter.
  logic                    unused_quo_hi;

  assign bus.in_ready  = (state_q == ACC) && !rst;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_q;
  assign bus.busy      = (state_q != ACC) || (cnt_q != 8'd0);

  assign fire     = bus.in_valid && bus.in_ready;
  assign first    = (cnt_q == 8'd0);
  assign mode_eff = first ? bus.cfg_mode : mode_q;
  assign win_eff  = first ? clip_win(bus.cfg_win, WIN_MAX) : win_q;
  assign last     = fire && ((cnt_q + 8'd1) == win_eff);

  // Per-lane accumulate / running-max update for the beat on the bus.
  always_comb begin
    max_pack = '0;
    for (int k = 0; k < CH; k++) begin
      sext[k] = {{(ACC_W-ACT_W){bus.in_data[k*ACT_W+ACT_W-1]}}, bus.in_data[k*ACT_W +: ACT_W]};
      acc_nxt[k] = acc_q[k];
      if (first)
        acc_nxt[k] = sext[k];
      else if (mode_eff == MODE_AVG)
        acc_nxt[k] = acc_q[k] + sext[k];
      else if (sext[k] > acc_q[k])
        acc_nxt[k] = sext[k];
      max_pack[k*ACT_W +: ACT_W] = acc_nxt[k][ACT_W-1:0];
    end
  end

  // Divide the magnitude, then restore the sign: truncation toward zero.
  assign div_sel       = acc_q[lane_q];
  assign div_mag       = div_sel[ACC_W-1] ? -div_sel : div_sel;
  assign div_den       = ACC_W'(win_q);
  assign quo_lo        = div_quo[ACT_W-1:0];
  assign div_res       = div_sel[ACC_W-1] ? -quo_lo : quo_lo;
  assign unused_quo_hi = ^div_quo[ACC_W-1:ACT_W];

  seq_div #(.ACC_W(ACC_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_q),
    .dividend (div_mag),
    .divisor  (div_den),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Next-state logic: ACC collects a window, DIV divides lane by lane, OUT waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: if (last) state_d = (mode_eff == MODE_AVG) ? DIV : OUT;
      DIV: if (div_done && (lane_q == LANE_W'(CH - 1))) state_d = OUT;
      OUT: if (bus.out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  // Window bookkeeping, accumulators, lane sequencing and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 8'd0;
      mode_q      <= MODE_AVG;
      win_q       <= 8'd1;
      lane_q      <= '0;
      div_start_q <= 1'b0;
      out_q       <= '0;
      for (int k = 0; k < CH; k++) acc_q[k] <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        ACC: if (fire) begin
          for (int k = 0; k < CH; k++) acc_q[k] <= acc_nxt[k];
          if (first) begin
            mode_q <= bus.cfg_mode;
            win_q  <= win_eff;
          end
          if (last) begin
            cnt_q  <= 8'd0;
            lane_q <= '0;
            if (mode_eff == MODE_AVG) div_start_q <= 1'b1;
            else                      out_q       <= max_pack;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DIV: if (div_done) begin
          out_q[lane_q*ACT_W +: ACT_W] <= div_res;
          if (lane_q != LANE_W'(CH - 1)) begin
            lane_q      <= lane_q + LANE_W'(1);
            div_start_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_unit.sv
// Directed testbench for pool_unit with hand-computed expected results.
module tb_pool_unit;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pool_unit_if #(.ACT_W(8), .CH(4)) bus ();

  pool_unit #(.ACT_W(8), .CH(4), .WIN_MAX(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_ov_low"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_in_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_mode  = MODE_AVG;
    bus.cfg_win   = 8'd4;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Average, window 4: lanes {-128 x4, -1 x4, 1..4, 10/20/30/41}
    send_beat(32'h80FF010A);
    chk("avg4_busy", {31'd0, bus.busy}, 32'd1);
    send_beat(32'h80FF0214);
    send_beat(32'h80FF031E);
    send_beat(32'h80FF0429);
    chk("avg4_div_in_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_out("avg4", 56);
    chk("avg4_data", bus.out_data, 32'h80FF0219);
    consume("avg4");

    // Average, window 3: truncation toward zero on negative sums
    bus.cfg_win = 8'd3;
    send_beat(32'hFF64FB07);
    send_beat(32'h0064FB07);
    send_beat(32'h0064FA08);
    wait_out("avg3", 56);
    chk("avg3_data", bus.out_data, 32'h0064FB07);
    consume("avg3");

    // Average, window 64 at the accumulator extremes
    bus.cfg_win = 8'd64;
    for (int i = 0; i < 64; i++) send_beat(32'h017F0080);
    wait_out("avg64", 56);
    chk("avg64_data", bus.out_data, 32'h017F0080);
    consume("avg64");

    // Max, window 5; cfg changed after the first beat must be ignored
    bus.cfg_mode = MODE_MAX;
    bus.cfg_win  = 8'd5;
    send_beat(32'h807F8001);
    bus.cfg_mode = MODE_AVG;
    bus.cfg_win  = 8'd2;
    send_beat(32'hFD008005);
    send_beat(32'hA6008005);
    send_beat(32'hFD008002);
    bus.out_ready = 1'b0;
    send_beat(32'h9C008000);
    wait_out("max5", 0);
    chk("max5_data", bus.out_data, 32'hFD7F8005);

    // Back-pressure: result held, input refused
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h11111111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_out_data", bus.out_data, 32'hFD7F8005);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("hs_beat_not_taken", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = 1'b0;

    // Window 0 acts as window 1 in both modes
    bus.cfg_mode = MODE_AVG;
    bus.cfg_win  = 8'd0;
    send_beat(32'h817F00FE);
    wait_out("win0_avg", 56);
    chk("win0_avg_data", bus.out_data, 32'h817F00FE);
    consume("win0_avg");
    bus.cfg_mode = MODE_MAX;
    send_beat(32'h12F05688);
    wait_out("win0_max", 0);
    chk("win0_max_data", bus.out_data, 32'h12F05688);
    consume("win0_max");

    // Window 200 clips to 64
    bus.cfg_mode = MODE_AVG;
    bus.cfg_win  = 8'd200;
    for (int i = 0; i < 63; i++) send_beat(32'h00000002);
    chk("win200_still_acc", {31'd0, bus.in_ready}, 32'd1);
    send_beat(32'h00000042);
    wait_out("win200", 56);
    chk("win200_data", bus.out_data, 32'h00000003);
    consume("win200");

    // Reset in the middle of DIV, then a clean window
    bus.cfg_win = 8'd2;
    send_beat(32'h10101010);
    send_beat(32'h10101010);
    for (int i = 0; i < 20; i++) tick();
    chk("div_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_out_data", bus.out_data, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    send_beat(32'h0000FD03);
    send_beat(32'h0000FC04);
    wait_out("post_rst", 56);
    chk("post_rst_data", bus.out_data, 32'h0000FD03);
    consume("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
